// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package : uart_pkg
// Brief   : Shared UART constants, arbiter state encoding and helpers.
// Rev     : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } uart_arb_state_t;

    // Increment with explicit wrap so non-power-of-2 requester counts stay in range.
    function automatic int unsigned uart_wrap_inc(input int unsigned idx, input int unsigned n);
        return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : uart_rr_pick
// Brief  : Combinational rotating-priority encoder; searches upward from ptr.
// Rev    : 1.0  initial release
// ============================================================================
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_winner_oh,
    output logic [PTR_W-1:0] o_winner_idx,
    output logic             o_any
);

    logic [PTR_W:0] w_pos;

    // Walk offsets from the far end down so the nearest requester above ptr wins.
    always_comb begin
        o_winner_idx = '0;
        o_winner_oh  = '0;
        w_pos        = '0;
        o_any        = |i_req;
        for (int off = N - 1; off >= 0; off--) begin
            w_pos = {1'b0, i_ptr} + (PTR_W + 1)'(off);
            if (w_pos >= (PTR_W + 1)'(N)) begin
                w_pos = w_pos - (PTR_W + 1)'(N);
            end
            if (i_req[w_pos[PTR_W-1:0]]) begin
                o_winner_idx = w_pos[PTR_W-1:0];
            end
        end
        if (o_any) begin
            o_winner_oh[o_winner_idx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_arbiter
// Brief  : Round-robin, frame-locked arbiter in front of the UART TX byte port.
//          Optional lock watchdog enabled by defining UART_ARB_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = UART_DATA_W,
    parameter int TIMEOUT = 1023
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    input  logic                      out_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      timeout_pulse
);

    localparam int PTR_W = $clog2(NUM_REQ);

    uart_arb_state_t    state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               busy_q, busy_d;

    logic [NUM_REQ-1:0] w_pick_oh;
    logic [PTR_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic               w_valid_sel;
    logic               w_last_sel;
    logic               w_xfer;
    logic               w_timeout;
    logic [PTR_W-1:0]   w_ptr_next;

    uart_rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .i_req        (req_valid),
        .i_ptr        (ptr_q),
        .o_winner_oh  (w_pick_oh),
        .o_winner_idx (w_pick_idx),
        .o_any        (w_pick_any)
    );

    // Byte path is a pure mux off the registered one-hot grant; idle grant gives zeros.
    always_comb begin
        w_valid_sel = |(req_valid & grant_q);
        w_last_sel  = |(req_last & grant_q);
        out_data    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                out_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign out_valid  = w_valid_sel;
    assign req_ready  = grant_q & {NUM_REQ{out_ready}};
    assign w_xfer     = w_valid_sel & out_ready;
    assign w_ptr_next = PTR_W'(uart_wrap_inc(32'(owner_q), NUM_REQ));
    assign grant      = grant_q;
    assign busy       = busy_q;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tpulse_q;
    logic             w_expired;

    assign w_expired = (cnt_q == CNT_W'(TIMEOUT));
    // A transfer in the expiry cycle wins over the forced release.
    assign w_timeout = busy_q & ~w_xfer & w_expired;

    always_comb begin
        cnt_d = cnt_q;
        if (!busy_q || w_xfer) begin
            cnt_d = '0;
        end else if (!w_valid_sel && !w_expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            tpulse_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            tpulse_q <= w_timeout;
        end
    end

    assign timeout_pulse = tpulse_q;
`else
    logic timeout_unused;

    assign timeout_unused = (TIMEOUT > 0);
    assign w_timeout      = 1'b0;
    assign timeout_pulse  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        case (state_q)
            ARB_IDLE: begin
                if (w_pick_any) begin
                    state_d = ARB_LOCK;
                    owner_d = w_pick_idx;
                    grant_d = w_pick_oh;
                    busy_d  = 1'b1;
                end
            end
            ARB_LOCK: begin
                // Releasing always lands in IDLE, which guarantees a gap cycle between frames.
                if ((w_xfer && w_last_sel) || w_timeout) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    ptr_d   = w_ptr_next;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_tx_arbiter
// Brief  : Directed self-checking bench for uart_tx_arbiter (UART_ARB_TIMEOUT_EN optional).
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;

    localparam logic [3:0] C_CONT_GRANT [8] = '{4'b0001, 4'b0000, 4'b0100, 4'b0000,
                                                4'b1000, 4'b0000, 4'b0001, 4'b0000};
    localparam logic [7:0] C_CONT_DATA  [8] = '{8'hA0, 8'h00, 8'hA2, 8'h00,
                                                8'hA3, 8'h00, 8'hA0, 8'h00};
    localparam logic [7:0] C_SINGLE     [3] = '{8'h41, 8'h42, 8'h43};
    localparam logic [7:0] C_FRAME      [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
    localparam logic [7:0] C_RSTF       [2] = '{8'h20, 8'h21};

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_last;
    logic [NR-1:0]    req_ready;
    logic             out_valid;
    logic [DW-1:0]    out_data;
    logic             out_ready;
    logic [NR-1:0]    grant;
    logic             busy;
    logic             timeout_pulse;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_arbiter #(
        .NUM_REQ (NR),
        .DATA_W  (DW),
        .TIMEOUT (15)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .grant         (grant),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_byte(input int i, input logic [7:0] b);
        req_data[i*DW +: DW] = b;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_grant"}, 32'(grant), 32'h0);
        check_eq({tag, "_busy"}, 32'(busy), 32'h0);
        check_eq({tag, "_ovalid"}, 32'(out_valid), 32'h0);
        check_eq({tag, "_ready"}, 32'(req_ready), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with requesters 0, 2, 3 already holding one-byte frames.
        rst       = 1'b0;
        out_ready = 1'b1;
        req_data  = '0;
        req_valid = 4'b1101;
        req_last  = 4'b1101;
        set_byte(0, 8'hA0);
        set_byte(2, 8'hA2);
        set_byte(3, 8'hA3);
        repeat (2) cyc();
        check_idle("rst");
        check_eq("rst_odata", 32'(out_data), 32'h0);
        check_eq("rst_tpulse", 32'(timeout_pulse), 32'h0);

        rst = 1'b1;
        #1;
        check_eq("cont_first_idle", 32'(grant), 32'h0);
        for (int i = 0; i < 8; i++) begin
            cyc();
            check_eq($sformatf("cont_grant_%0d", i), 32'(grant), 32'(C_CONT_GRANT[i]));
            check_eq($sformatf("cont_data_%0d", i), 32'(out_data), 32'(C_CONT_DATA[i]));
        end
        req_valid = '0;
        req_last  = '0;

        // Single requester 1, three-byte frame (ptr is 1 here).
        cyc();
        req_valid = 4'b0010;
        set_byte(1, 8'h41);
        #1;
        check_eq("single_wait", 32'(grant), 32'h0);
        cyc();
        for (int k = 0; k < 3; k++) begin
            set_byte(1, C_SINGLE[k]);
            req_last = (k == 2) ? 4'b0010 : 4'b0000;
            #1;
            check_eq($sformatf("single_grant_%0d", k), 32'(grant), 32'h2);
            check_eq($sformatf("single_data_%0d", k), 32'(out_data), 32'(C_SINGLE[k]));
            check_eq($sformatf("single_ready_%0d", k), 32'(req_ready), 32'h2);
            check_eq($sformatf("single_busy_%0d", k), 32'(busy), 32'h1);
            cyc();
        end
        req_valid = '0;
        req_last  = '0;
        #1;
        check_idle("single_end");

        // ptr should now be 2: between requesters 0 and 3, requester 3 wins.
        req_valid = 4'b1001;
        req_last  = 4'b1001;
        set_byte(0, 8'hB0);
        set_byte(3, 8'hB3);
        cyc();
        check_eq("ptr2_grant", 32'(grant), 32'h8);
        check_eq("ptr2_data", 32'(out_data), 32'hB3);
        cyc();
        req_valid = '0;
        req_last  = '0;
        #1;
        check_eq("ptr2_release", 32'(grant), 32'h0);

        // Requester 0 four-byte frame with requester 1 waiting; stall 10 cycles mid-frame.
        req_valid = 4'b0011;
        req_last  = 4'b0010;
        set_byte(0, C_FRAME[0]);
        set_byte(1, 8'h55);
        cyc();
        for (int k = 0; k < 4; k++) begin
            set_byte(0, C_FRAME[k]);
            req_last[0] = (k == 3);
            if (k == 1) begin
                out_ready = 1'b0;
                for (int j = 0; j < 10; j++) begin
                    #1;
                    check_eq($sformatf("bp_grant_%0d", j), 32'(grant), 32'h1);
                    check_eq($sformatf("bp_data_%0d", j), 32'(out_data), 32'(C_FRAME[1]));
                    check_eq($sformatf("bp_ready_%0d", j), 32'(req_ready), 32'h0);
                    check_eq($sformatf("bp_ovalid_%0d", j), 32'(out_valid), 32'h1);
                    cyc();
                end
                out_ready = 1'b1;
            end
            #1;
            check_eq($sformatf("frame_grant_%0d", k), 32'(grant), 32'h1);
            check_eq($sformatf("frame_data_%0d", k), 32'(out_data), 32'(C_FRAME[k]));
            check_eq($sformatf("frame_ready_%0d", k), 32'(req_ready), 32'h1);
            cyc();
        end
        req_valid[0] = 1'b0;
        req_last[0]  = 1'b0;
        #1;
        check_idle("eof_gap");
        cyc();
        check_eq("next_grant", 32'(grant), 32'h2);
        check_eq("next_data", 32'(out_data), 32'h55);
        check_eq("next_ready", 32'(req_ready), 32'h2);
        cyc();
        req_valid = '0;
        req_last  = '0;
        #1;
        check_eq("next_release", 32'(grant), 32'h0);

        // ptr is 2: requester 2 wins, two bytes go out, then reset mid-frame.
        req_valid = 4'b0110;
        req_last  = 4'b0010;
        set_byte(1, 8'h66);
        set_byte(2, C_RSTF[0]);
        cyc();
        check_eq("rm_grant", 32'(grant), 32'h4);
        for (int k = 0; k < 2; k++) begin
            set_byte(2, C_RSTF[k]);
            #1;
            check_eq($sformatf("rm_data_%0d", k), 32'(out_data), 32'(C_RSTF[k]));
            cyc();
        end
        set_byte(2, 8'h22);
        #1;
        rst = 1'b0;
        #1;
        check_idle("rm_async");
        check_eq("rm_async_odata", 32'(out_data), 32'h0);
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        check_eq("rm_post_idle", 32'(grant), 32'h0);
        cyc();
        check_eq("rm_regrant", 32'(grant), 32'h2);
        check_eq("rm_regrant_data", 32'(out_data), 32'h66);
        cyc();
        req_valid = '0;
        req_last  = '0;
        #1;
        check_idle("rm_end");

`ifdef UART_ARB_TIMEOUT_EN
        begin : b_timeout
            int  n_to;
            bit  found;
            n_to  = 0;
            found = 1'b0;
            // ptr is 2: requester 3 is granted, sends one non-last byte, then goes quiet.
            req_valid = 4'b1000;
            req_last  = 4'b0000;
            set_byte(3, 8'h77);
            cyc();
            check_eq("to_grant", 32'(grant), 32'h8);
            cyc();
            req_valid = '0;
            for (int j = 1; j <= 40 && !found; j++) begin
                cyc();
                if (timeout_pulse) begin
                    found = 1'b1;
                    n_to  = j;
                end
            end
            check_eq("to_latency", 32'(n_to), 32'd16);
            check_idle("to_release");
            cyc();
            check_eq("to_pulse_width", 32'(timeout_pulse), 32'h0);
            req_valid = 4'b0011;
            req_last  = 4'b0011;
            cyc();
            check_eq("to_ptr_wrap", 32'(grant), 32'h1);
            cyc();
            req_valid = '0;
            req_last  = '0;
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
